wb_arbiter: RTL and testbench

//  Write-back stage directly upstream of the register file. Merges single-cycle ALU results with

---
 rtl/riscv_structures.sv | 25 ++
 rtl/wb_fifo.sv | 52 +++++
 rtl/wb_arbiter.sv | 140 ++++++++++++++
 tb/tb_wb_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_structures.sv
// ============================================================================
// riscv_structures : shared write-back types and widths
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_structures;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LSU  = 2'd2
  } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// wb_fifo : small FIFO of write-back entries, pointer MSB disambiguates full/empty
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_fifo
  import riscv_structures::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int c_addr_w = $clog2(DEPTH);

  typedef logic [c_addr_w:0] ptr_t;

  ptr_t      r_wr_ptr;
  ptr_t      r_rd_ptr;
  wb_entry_t r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + ptr_t'(1);
    end
  end

  // Storage carries no reset; validity is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr[c_addr_w-1:0]] <= din;
  end

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                 (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
  assign head  = r_mem[r_rd_ptr[c_addr_w-1:0]];

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// wb_arbiter : merges ALU and LSU results onto the register-file write port
//              and tracks outstanding long-latency destinations
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_arbiter
  import riscv_structures::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_stall,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0]     lsu_data,
  input  logic                  issue_long,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] chk_rs1,
  input  logic [REG_ADDR_W-1:0] chk_rs2,
  input  logic [REG_ADDR_W-1:0] chk_rd,
  output logic                  hazard,
  output logic [REG_ADDR_W-1:0] a3,
  output logic                  we3,
  output logic [DATA_W-1:0]     wd,
  output logic                  proto_err
);

  localparam int                c_cnt_w      = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIMIT);

  logic                  w_full;
  logic                  w_empty;
  wb_entry_t             w_head;
  wb_entry_t             w_sel;
  wb_src_e               w_src;
  logic                  w_alu_go;
  logic                  w_lsu_hs;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_sel_nz;
  logic                  w_lsu_sel;
  logic [31:0]           w_busy_nxt;

  logic [31:0]           r_busy;
  logic [c_cnt_w-1:0]    r_starve_cnt;
  logic                  r_proto_err;
  logic [REG_ADDR_W-1:0] r_a3;
  logic                  r_we3;
  logic [DATA_W-1:0]     r_wd;
  logic                  r_src_lsu;

  assign alu_stall = w_full || (r_starve_cnt == c_starve_max);
  assign lsu_ready = !w_full;
  assign w_alu_go  = alu_valid && !alu_stall;
  assign w_lsu_hs  = lsu_valid && lsu_ready;
  assign w_pop     = !w_empty && !w_alu_go;
  // Only an empty FIFO with no ALU write lets the LSU bypass; otherwise it queues.
  assign w_push    = w_lsu_hs && !(w_empty && !w_alu_go);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   ('{rd: lsu_rd, data: lsu_data}),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_src = WB_NONE;
    w_sel = '0;
    if (w_pop) begin
      w_src = WB_LSU;
      w_sel = w_head;
    end else if (w_alu_go) begin
      w_src = WB_ALU;
      w_sel = '{rd: alu_rd, data: alu_data};
    end else if (w_lsu_hs) begin
      w_src = WB_LSU;
      w_sel = '{rd: lsu_rd, data: lsu_data};
    end
  end

  assign w_sel_nz  = |w_sel.rd;
  assign w_lsu_sel = (w_src == WB_LSU);

  // Clear follows the regfile commit of an LSU write; a same-edge issue re-arms the bit.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_we3 && r_src_lsu) w_busy_nxt[r_a3] = 1'b0;
    if (issue_long && (issue_rd != '0)) w_busy_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy       <= '0;
      r_starve_cnt <= '0;
      r_proto_err  <= 1'b0;
      r_a3         <= '0;
      r_we3        <= 1'b0;
      r_wd         <= '0;
      r_src_lsu    <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_a3      <= w_sel.rd;
      r_wd      <= w_sel.data;
      r_we3     <= (w_src != WB_NONE) && w_sel_nz;
      r_src_lsu <= w_lsu_sel && w_sel_nz;

      if (w_pop || w_empty)
        r_starve_cnt <= '0;
      else if (w_alu_go && (r_starve_cnt != c_starve_max))
        r_starve_cnt <= r_starve_cnt + c_cnt_w'(1);

      if ((alu_valid && alu_stall) || (w_lsu_sel && w_sel_nz && !r_busy[w_sel.rd]))
        r_proto_err <= 1'b1;
    end
  end

  assign hazard    = r_busy[chk_rs1] | r_busy[chk_rs2] | r_busy[chk_rd];
  assign a3        = r_a3;
  assign we3       = r_we3;
  assign wd        = r_wd;
  assign proto_err = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// tb_wb_arbiter : directed scenarios plus random traffic against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_arbiter;
  import riscv_structures::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, issue_long;
  logic [4:0]  alu_rd, lsu_rd, issue_rd, chk_rs1, chk_rs2, chk_rd;
  logic [31:0] alu_data, lsu_data;
  logic        alu_stall, lsu_ready, hazard, we3, proto_err;
  logic [4:0]  a3;
  logic [31:0] wd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_long(issue_long), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .hazard(hazard),
    .a3(a3), .we3(we3), .wd(wd), .proto_err(proto_err)
  );

  // Reference model: pending LSU results as a queue, busy as a bit array.
  wb_entry_t   q[$];
  bit          m_busy[32];
  int          m_starve;
  bit          m_perr;
  bit          m_we3;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  bit          m_from_lsu;
  logic [31:0] rf_dut[32];

  function automatic bit m_stall();
    return (q.size() == DEPTH) || (m_starve == LIMIT);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_starve = 0; m_perr = 1'b0; m_we3 = 1'b0; m_a3 = '0; m_wd = '0; m_from_lsu = 1'b0;
  endtask

  task automatic model_step();
    bit        full, stall, alu_takes, hs, have, from_lsu, popped, bypassed;
    int        size_before;
    wb_entry_t sel;
    size_before = q.size();
    full      = (size_before == DEPTH);
    stall     = m_stall();
    alu_takes = alu_valid && !stall;
    hs        = lsu_valid && !full;
    have = 0; from_lsu = 0; popped = 0; bypassed = 0; sel = '0;
    if (alu_valid && stall) m_perr = 1'b1;
    if (size_before > 0 && !alu_takes) begin
      sel = q.pop_front(); have = 1; from_lsu = 1; popped = 1;
    end else if (alu_takes) begin
      sel.rd = alu_rd; sel.data = alu_data; have = 1;
    end else if (hs) begin
      sel.rd = lsu_rd; sel.data = lsu_data; have = 1; from_lsu = 1; bypassed = 1;
    end
    if (hs && !bypassed) q.push_back('{rd: lsu_rd, data: lsu_data});
    if (from_lsu && sel.rd != 0 && !m_busy[sel.rd]) m_perr = 1'b1;
    if (m_we3 && m_from_lsu) m_busy[m_a3] = 1'b0;
    if (issue_long && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    if (popped || size_before == 0) m_starve = 0;
    else if (alu_takes && m_starve < LIMIT) m_starve++;
    m_we3      = have && (sel.rd != 0);
    m_a3       = sel.rd;
    m_wd       = sel.data;
    m_from_lsu = from_lsu && (sel.rd != 0);
  endtask

  // Check outputs against the model, advance the model, then cross one edge.
  task automatic tick();
    #1;
    chk("we3", we3, m_we3);
    if (m_we3) begin
      chk("a3", a3, m_a3);
      chk("wd", wd, m_wd);
    end
    chk("lsu_ready", lsu_ready, q.size() != DEPTH);
    chk("alu_stall", alu_stall, m_stall());
    chk("hazard", hazard, m_busy[chk_rs1] | m_busy[chk_rs2] | m_busy[chk_rd]);
    chk("proto_err", proto_err, m_perr);
    if (we3) rf_dut[a3] = wd;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_long = 0; issue_rd = 0;
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    foreach (rf_dut[i]) rf_dut[i] = '0;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_a3", a3, 0);
    chk("rst_we3", we3, 0);
    chk("rst_wd", wd, 0);
    chk("rst_lsu_ready", lsu_ready, 1);
    chk("rst_alu_stall", alu_stall, 0);
    chk("rst_proto_err", proto_err, 0);
    rst = 1'b0;
    model_reset();
    tick();

    // ALU only
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    tick();
    alu_valid = 0;
    chk("alu_we3", we3, 1);
    chk("alu_a3", a3, 5);
    chk("alu_wd", wd, 32'h1234);
    tick();
    chk("rf_x5", rf_dut[5], 32'h1234);

    // LSU bypass and busy release on commit
    issue_long = 1; issue_rd = 7;
    tick();
    issue_long = 0;
    chk_rs1 = 7; lsu_valid = 1; lsu_rd = 7; lsu_data = 32'hCAFE;
    #1;
    chk("byp_hazard_pre", hazard, 1);
    tick();
    lsu_valid = 0;
    chk("byp_we3", we3, 1);
    chk("byp_a3", a3, 7);
    chk("byp_wd", wd, 32'hCAFE);
    chk("byp_hazard_hold", hazard, 1);
    tick();
    chk("byp_hazard_clr", hazard, 0);
    chk_rs1 = 0;

    // Contention: FIFO fills while the ALU writes every cycle
    for (int i = 0; i < 5; i++) begin
      issue_long = 1; issue_rd = 5'(10 + i);
      tick();
    end
    issue_long = 0;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 5'(20 + i); alu_data = $urandom;
      lsu_valid = 1; lsu_rd = 5'(10 + i); lsu_data = 32'hA000 + i;
      tick();
    end
    chk("full_lsu_ready", lsu_ready, 0);
    chk("full_alu_stall", alu_stall, 1);
    sent = 4;
    for (int c = 0; c < 60; c++) begin
      bit fire;
      lsu_valid = (sent < 5); lsu_rd = 5'(10 + sent); lsu_data = 32'hA000 + sent;
      alu_valid = !m_stall(); alu_rd = 5'(20 + (c % 8)); alu_data = $urandom;
      fire = lsu_valid && (q.size() != DEPTH);
      tick();
      if (fire) sent++;
    end
    idle_inputs();
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk_rs1 = 5'(10 + i);
      #1;
      chk("drain_hazard", hazard, 0);
    end
    chk_rs1 = 0;

    // Starvation: one queued entry against continuous ALU traffic
    issue_long = 1; issue_rd = 15;
    tick();
    issue_long = 0;
    alu_valid = 1; alu_rd = 21; alu_data = 32'h1;
    lsu_valid = 1; lsu_rd = 15; lsu_data = 32'hBEEF;
    tick();
    lsu_valid = 0;
    for (int i = 0; i < LIMIT; i++) begin
      chk("starve_no_stall", alu_stall, 0);
      alu_data = $urandom;
      tick();
    end
    chk("starve_stall", alu_stall, 1);
    alu_valid = 0;
    tick();
    chk("starve_we3", we3, 1);
    chk("starve_a3", a3, 15);
    chk("starve_wd", wd, 32'hBEEF);
    chk("starve_release", alu_stall, 0);
    tick();

    // x0 and protocol error
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h55;
    #1;
    chk("x0_ready", lsu_ready, 1);
    tick();
    lsu_valid = 0;
    chk("x0_we3", we3, 0);
    chk("x0_perr", proto_err, 0);
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h77;
    tick();
    lsu_valid = 0;
    chk("perr_we3", we3, 1);
    chk("perr_a3", a3, 3);
    chk("perr_set", proto_err, 1);
    tick(); tick();
    chk("perr_sticky", proto_err, 1);

    // Reset during drain with three queued entries
    for (int i = 0; i < 3; i++) begin
      issue_long = 1; issue_rd = 5'(16 + i);
      tick();
    end
    issue_long = 0;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 5'(24 + i); alu_data = $urandom;
      lsu_valid = 1; lsu_rd = 5'(16 + i); lsu_data = 32'hD000 + i;
      tick();
    end
    idle_inputs();
    chk_rs1 = 16; chk_rs2 = 17; chk_rd = 18;
    tick();
    chk("drain_we3", we3, 1);
    chk("drain_a3", a3, 16);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_we3", we3, 0);
    chk("arst_a3", a3, 0);
    chk("arst_wd", wd, 0);
    chk("arst_lsu_ready", lsu_ready, 1);
    chk("arst_hazard", hazard, 0);
    chk("arst_perr", proto_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    idle_inputs();
    tick();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      alu_valid  = (($urandom % 10) < 6) && (!m_stall() || (($urandom % 50) == 0));
      alu_rd     = 5'($urandom);
      alu_data   = $urandom;
      lsu_valid  = 1'($urandom);
      lsu_rd     = 5'($urandom);
      lsu_data   = $urandom;
      issue_long = (($urandom % 3) == 0);
      issue_rd   = 5'($urandom);
      chk_rs1    = 5'($urandom);
      chk_rs2    = 5'($urandom);
      chk_rd     = 5'($urandom);
      tick();
    end
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
